axi_burst_mem: RTL and testbench
================================

# axi_burst_mem

AXI4 burst-capable slave memory, the parametrised successor to the single-beat `slave_axi`. It accepts FIXED, INCR and WRAP bursts of up to 256 beats on independent read and write channels, with configurable data width, ID width and memory depth. Byte strobes and SLVERR error responses are supported. It sits behind any AXI4 master in the AXI testbench environment as the reference target memory.

## Interface
- ADDR_WIDTH, 32, byte-address width of awaddr/araddr
- DATA_WIDTH, 32, data bus width in bits; one of 32, 64 or 128
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 256, number of DATA_WIDTH-bit words; must be a power of two
- aclk  in  1  clock; all logic is on the rising edge
- areset  in  1  reset, asynchronous assert, active-high
- awid/awaddr/awlen/awburst  in  ID_WIDTH/ADDR_WIDTH/8/2  write address channel
- awvalid in 1, awready out 1  AW handshake
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
- wvalid in 1, wready out 1  W handshake
- bid/bresp  out  ID_WIDTH/2  write response
- bvalid out 1, bready in 1  B handshake
- arid/araddr/arlen/arburst  in  ID_WIDTH/ADDR_WIDTH/8/2  read address channel
- arvalid in 1, arready out 1  AR handshake
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data channel
- rvalid out 1, rready in 1  R handshake

## Operation
- BYTES = DATA_WIDTH/8. Word index = addr >> log2(BYTES). Low address bits are ignored, so all accesses are aligned.
- Beat count is len+1.
- Next-address rule, by burst type:
  - FIXED (0): address constant across the burst.
  - INCR (1): address += BYTES per beat.
  - WRAP (2): address wraps within an aligned block of (len+1)*BYTES.
- An access is out of range when its word index >= MEM_DEPTH. This is evaluated per beat.
- Error conditions, each giving SLVERR (2x):
  - burst=3, or WRAP with len not in {1,3,7,15}: the whole burst takes SLVERR. No memory writes occur; reads return 0.
  - Out-of-range beat: that beat is not written; a read beat returns 0 with SLVERR. The B response is SLVERR if any beat erred.
  - wlast asserted early, or absent on the final beat. The burst still ends after len+1 beats.
- Otherwise the response is OKAY (00).
- Write FSM: W_IDLE -> W_DATA on AW handshake -> W_RESP after final W handshake -> W_IDLE on B handshake.
- Read FSM: R_IDLE -> R_DATA on AR handshake -> R_IDLE on the R handshake with rlast=1.
- Writes honour wstrb per byte. Memory contents are not reset.
- Read and write channels are fully independent. Each accepts one outstanding burst.
- If a read and a write hit the same word in the same cycle, the read returns the pre-write data.

## Timing
- Output reset values: awready=0, wready=0, bvalid=0, bresp=0, bid=0, arready=0, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0.
- On the first rising edge after areset falls, awready=1 and arready=1.
- awready=1 only in W_IDLE; arready=1 only in R_IDLE. Both are registered.
- wready rises the cycle after the AW handshake and stays 1 through W_DATA. Each W handshake writes the memory on that edge.
- bvalid rises the cycle after the final W handshake. bid equals the captured awid. bvalid/bid/bresp are held until bready.
- rvalid rises the cycle after the AR handshake, so first-beat latency is 1 cycle.
- One beat per cycle while rready=1. rid equals the captured arid. rlast=1 on beat len+1 only.
- While rvalid=1 and rready=0, rdata/rresp/rlast are held stable.
- awready/arready return to 1 the cycle after the final B/R handshake. Back-to-back bursts therefore lose one cycle per burst.
- Reset mid-burst: both FSMs return to idle immediately and all outputs take their reset values. Beats already written remain in memory.

## Test plan
- Single beat: AW addr=0x10, len=0, INCR; W data=0xDEADBEEF, strb=0xF, last=1; then AR addr=0x10 -> bresp=00, rdata=0xDEADBEEF, rlast=1, rid=arid.
- INCR 4 beats at 0x20 with data 1..4, then read 4 beats at 0x20 -> rdata sequence 1,2,3,4 with OKAY; rlast only on beat 4.
- WRAP len=3 at 0x38 (DATA_WIDTH=32) -> beats go to 0x38, 0x3C, 0x30, 0x34. A subsequent INCR read from 0x30 returns data in the order beat3, beat4, beat1, beat2.
- Strobe merge: write 0xFFFFFFFF to 0x40, then write 0x12345678 with strb=0x5 -> read 0x40 returns 0xFF34FF78.
- Errors:
  - Write to addr MEM_DEPTH*4 -> bresp=10, memory unchanged.
  - awburst=3 -> bresp=10.
  - WRAP with len=2 -> SLVERR.
  - Read out of range -> rresp=10, rdata=0.
- rready toggled 1,0,0,1 during a 4-beat read -> rdata stable while stalled, 4 beats delivered. Then assert areset mid-burst -> rvalid=0 asynchronously, arready=1 one edge after release.

Source files
------------

// File: rtl/axi_burst_mem.sv
// ---------------------------------------------------------------------------
// axi_burst_mem
//
// AXI4 slave memory that accepts FIXED, INCR and WRAP bursts of up to 256
// beats. Read and write channels run independently; each channel holds one
// outstanding burst at a time. Byte strobes are honoured. Illegal bursts and
// out-of-range beats answer with SLVERR. Memory contents are not reset.
//
// Parameters
//   ADDR_WIDTH  byte-address width of awaddr/araddr
//   DATA_WIDTH  data bus width (32, 64 or 128)
//   ID_WIDTH    transaction ID width
//   MEM_DEPTH   number of DATA_WIDTH-bit words (power of two)
//
// Ports
//   i_aclk, i_areset                  clock, async active-high reset
//   AW: i_awid/i_awaddr/i_awlen/i_awburst/i_awvalid -> o_awready
//   W : i_wdata/i_wstrb/i_wlast/i_wvalid            -> o_wready
//   B : o_bid/o_bresp/o_bvalid                      <- i_bready
//   AR: i_arid/i_araddr/i_arlen/i_arburst/i_arvalid -> o_arready
//   R : o_rid/o_rdata/o_rresp/o_rlast/o_rvalid      <- i_rready
// ---------------------------------------------------------------------------
module axi_burst_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    i_aclk,
  input  logic                    i_areset,
  // write address channel
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  // write response channel
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  // read address channel
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  // read data channel
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] A_BYTES = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_DEPTH = ADDR_WIDTH'(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic       {R_IDLE, R_DATA}         rState_t;

  // A burst is legal for FIXED/INCR at any length; WRAP only for 2/4/8/16
  // beats; burst type 3 is reserved.
  function automatic logic burstLegal(input logic [7:0] len, input logic [1:0] burst);
    case (burst)
      2'b00, 2'b01: return 1'b1;
      2'b10:        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      default:      return 1'b0;
    endcase
  endfunction

  // Address of the following beat. WRAP keeps the high bits of the aligned
  // block and lets only the bits inside the block size roll over.
  function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic [7:0]            len,
                                                     input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] mask;
    mask = ((ADDR_WIDTH'(len) + A_ONE) << OFFS) - A_ONE;
    case (burst)
      2'b01:   return addr + A_BYTES;
      2'b10:   return (addr & ~mask) | ((addr + A_BYTES) & mask);
      default: return addr;
    endcase
  endfunction

  // The full address is compared so that any high bits above the memory
  // push the beat out of range instead of aliasing onto a low word.
  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> OFFS) < A_DEPTH;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  wState_t               r_wState;
  logic [ID_WIDTH-1:0]   r_wId;
  logic [ADDR_WIDTH-1:0] r_wAddr;
  logic [7:0]            r_wLen;
  logic [1:0]            r_wBurst;
  logic [7:0]            r_wBeat;
  logic                  r_wBadBurst;
  logic                  r_wErr;

  rState_t               r_rState;
  logic [ADDR_WIDTH-1:0] r_rAddr;
  logic [7:0]            r_rLen;
  logic [1:0]            r_rBurst;
  logic [7:0]            r_rBeat;
  logic                  r_rBadBurst;

  logic                  w_awFire;
  logic                  w_wFire;
  logic                  w_wLastBeat;
  logic                  w_wOk;
  logic                  w_wBeatErr;
  logic                  w_arFire;
  logic                  w_arOk;
  logic [DATA_WIDTH-1:0] w_arData;
  logic                  w_rFire;
  logic                  w_rOk;
  logic [DATA_WIDTH-1:0] w_rData;

  // Handshake detection and per-beat legality for both channels. The ready
  // outputs are only ever high in the state that may accept, so the fire
  // signals need no extra state qualification beyond the W channel.
  assign w_awFire    = i_awvalid && o_awready;
  assign w_wFire     = (r_wState == W_DATA) && i_wvalid && o_wready;
  assign w_wLastBeat = (r_wBeat == r_wLen);
  assign w_wOk       = !r_wBadBurst && inRange(r_wAddr);
  assign w_wBeatErr  = !w_wOk || (i_wlast != w_wLastBeat);

  assign w_arFire    = i_arvalid && o_arready;
  assign w_arOk      = burstLegal(i_arlen, i_arburst) && inRange(i_araddr);
  assign w_arData    = w_arOk ? r_mem[i_araddr[OFFS +: IDXW]] : '0;

  assign w_rFire     = o_rvalid && i_rready;
  assign w_rOk       = !r_rBadBurst && inRange(r_rAddr);
  assign w_rData     = w_rOk ? r_mem[r_rAddr[OFFS +: IDXW]] : '0;

  // Memory array: written on every accepted W beat that belongs to a legal
  // burst and lands inside the memory. No reset, so contents survive a reset
  // pulse. Reads sample the array on the same edge, which gives pre-write
  // data when both channels touch the same word together.
  always_ff @(posedge i_aclk) begin
    if (w_wFire && w_wOk) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_wstrb[b]) begin
          r_mem[r_wAddr[OFFS +: IDXW]][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Write FSM: take an AW, stream len+1 W beats while accumulating any
  // error, then hold the B response until the master accepts it. awready is
  // raised from W_IDLE on the cycle after reset or after the B handshake.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_wState    <= W_IDLE;
      r_wId       <= '0;
      r_wAddr     <= '0;
      r_wLen      <= '0;
      r_wBurst    <= '0;
      r_wBeat     <= '0;
      r_wBadBurst <= 1'b0;
      r_wErr      <= 1'b0;
      o_awready   <= 1'b0;
      o_wready    <= 1'b0;
      o_bvalid    <= 1'b0;
      o_bid       <= '0;
      o_bresp     <= RESP_OKAY;
    end else begin
      case (r_wState)
        W_IDLE: begin
          if (w_awFire) begin
            r_wState    <= W_DATA;
            r_wId       <= i_awid;
            r_wAddr     <= i_awaddr;
            r_wLen      <= i_awlen;
            r_wBurst    <= i_awburst;
            r_wBeat     <= '0;
            r_wBadBurst <= !burstLegal(i_awlen, i_awburst);
            r_wErr      <= 1'b0;
            o_awready   <= 1'b0;
            o_wready    <= 1'b1;
          end else begin
            o_awready   <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wFire) begin
            if (w_wLastBeat) begin
              r_wState <= W_RESP;
              o_wready <= 1'b0;
              o_bvalid <= 1'b1;
              o_bid    <= r_wId;
              o_bresp  <= (r_wErr || w_wBeatErr) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              r_wBeat  <= r_wBeat + 8'd1;
              r_wAddr  <= nextAddr(r_wAddr, r_wLen, r_wBurst);
              r_wErr   <= r_wErr || w_wBeatErr;
            end
          end
        end
        W_RESP: begin
          if (i_bready) begin
            r_wState  <= W_IDLE;
            o_bvalid  <= 1'b0;
            o_awready <= 1'b1;
          end
        end
        default: begin
          r_wState <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: the first beat is loaded straight from the AR request so it is
  // valid one cycle after the handshake. r_rAddr always points at the beat
  // after the one on the bus, so each R handshake loads the next beat with
  // no bubble. The output registers only change on a handshake, which keeps
  // them stable while the master stalls.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_rState    <= R_IDLE;
      r_rAddr     <= '0;
      r_rLen      <= '0;
      r_rBurst    <= '0;
      r_rBeat     <= '0;
      r_rBadBurst <= 1'b0;
      o_arready   <= 1'b0;
      o_rvalid    <= 1'b0;
      o_rlast     <= 1'b0;
      o_rdata     <= '0;
      o_rresp     <= RESP_OKAY;
      o_rid       <= '0;
    end else begin
      case (r_rState)
        R_IDLE: begin
          if (w_arFire) begin
            r_rState    <= R_DATA;
            r_rAddr     <= nextAddr(i_araddr, i_arlen, i_arburst);
            r_rLen      <= i_arlen;
            r_rBurst    <= i_arburst;
            r_rBeat     <= '0;
            r_rBadBurst <= !burstLegal(i_arlen, i_arburst);
            o_arready   <= 1'b0;
            o_rvalid    <= 1'b1;
            o_rlast     <= (i_arlen == 8'd0);
            o_rdata     <= w_arData;
            o_rresp     <= w_arOk ? RESP_OKAY : RESP_SLVERR;
            o_rid       <= i_arid;
          end else begin
            o_arready   <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_rFire) begin
            if (o_rlast) begin
              r_rState  <= R_IDLE;
              o_rvalid  <= 1'b0;
              o_rlast   <= 1'b0;
              o_arready <= 1'b1;
            end else begin
              r_rBeat   <= r_rBeat + 8'd1;
              r_rAddr   <= nextAddr(r_rAddr, r_rLen, r_rBurst);
              o_rlast   <= ((r_rBeat + 8'd1) == r_rLen);
              o_rdata   <= w_rData;
              o_rresp   <= w_rOk ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        default: begin
          r_rState <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_mem
//
// Drives write and read bursts into axi_burst_mem. Expected B responses and
// R beats come from a bench-side memory model and are queued when a burst is
// issued, then popped and compared as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_axi_burst_mem;

  logic        aclk;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bExp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rExp_t;

  bExp_t       bq[$];
  rExp_t       rq[$];
  logic [31:0] model [256];
  logic [31:0] wBuf  [16];
  int          checkCount = 0;
  int          failCount  = 0;

  axi_burst_mem #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .ID_WIDTH(4),
    .MEM_DEPTH(256)
  ) dut (
    .i_aclk(aclk),       .i_areset(areset),
    .i_awid(awid),       .i_awaddr(awaddr),   .i_awlen(awlen),   .i_awburst(awburst),
    .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata),     .i_wstrb(wstrb),     .i_wlast(wlast),
    .i_wvalid(wvalid),   .o_wready(wready),
    .o_bid(bid),         .o_bresp(bresp),     .o_bvalid(bvalid), .i_bready(bready),
    .i_arid(arid),       .i_araddr(araddr),   .i_arlen(arlen),   .i_arburst(arburst),
    .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid),         .o_rdata(rdata),     .o_rresp(rresp),   .o_rlast(rlast),
    .o_rvalid(rvalid),   .i_rready(rready)
  );

  // Free-running clock, 10 time units per period
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Hard stop in case a handshake loop ever stops making progress
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic bit burstLegal(input int unsigned len, input int unsigned burst);
    if (burst == 0 || burst == 1) return 1'b1;
    if (burst == 2) return (len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b0;
  endfunction

  // Byte address of beat i, derived from the block base and an offset modulo
  // the wrap size rather than by bit masking
  function automatic int unsigned beatAddr(input int unsigned start, input int unsigned len,
                                           input int unsigned burst, input int unsigned i);
    int unsigned size;
    int unsigned base;
    if (burst == 0) return start;
    if (burst == 1) return start + i * 4;
    size = (len + 1) * 4;
    base = (start / size) * size;
    return base + ((start - base) + i * 4) % size;
  endfunction

  // Issue one write burst from wBuf, queue its expected B and update the model
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] strb,
                               input bit earlyLast, input int bDelay);
    bit          legal;
    bit          err;
    int unsigned a;
    int          n;
    bExp_t       e;
    legal = burstLegal(len, burst);
    err   = !legal || earlyLast;
    for (int i = 0; i <= int'(len); i++) begin
      if (legal) begin
        a = beatAddr(addr, len, burst, i);
        if ((a / 4) >= 256) begin
          err = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (strb[b]) model[a / 4][b*8 +: 8] = wBuf[i][b*8 +: 8];
        end
      end
    end
    e.resp = err ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);

    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    checkOutput("awready", {31'b0, awready}, 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;

    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1;
      wdata  = wBuf[i];
      wstrb  = strb;
      wlast  = earlyLast ? (i == 0) : (i == int'(len));
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      checkOutput("wready", {31'b0, wready}, 32'd1);
      @(negedge aclk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;

    checkOutput("bvalid_latency", {31'b0, bvalid}, 32'd1);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    for (int k = 0; k < bDelay; k++) begin
      @(negedge aclk);
      checkOutput("bvalid_hold", {31'b0, bvalid}, 32'd1);
    end
    bready = 1'b1;
    if (bq.size() > 0) begin
      e = bq.pop_front();
      checkOutput("bresp", {30'b0, bresp}, {30'b0, e.resp});
      checkOutput("bid", {28'b0, bid}, {28'b0, e.id});
    end
    @(negedge aclk);
    bready = 1'b0;
    checkOutput("bvalid_clear", {31'b0, bvalid}, 32'd0);
    checkOutput("awready_return", {31'b0, awready}, 32'd1);
  endtask

  // Queue the expected beats of a read burst from the model
  task automatic pushRead(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
    rExp_t       e;
    int unsigned a;
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.last = (i == int'(len));
      if (!burstLegal(len, burst)) begin
        e.data = 32'h0; e.resp = 2'b10;
      end else begin
        a = beatAddr(addr, len, burst, i);
        if ((a / 4) >= 256) begin
          e.data = 32'h0; e.resp = 2'b10;
        end else begin
          e.data = model[a / 4]; e.resp = 2'b00;
        end
      end
      rq.push_back(e);
    end
  endtask

  task automatic arHandshake(input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst);
    int n;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    checkOutput("arready", {31'b0, arready}, 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    checkOutput("rvalid_latency", {31'b0, rvalid}, 32'd1);
  endtask

  // Read a burst; with stall set, rready follows 1,0,0,1 then stays high
  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit stall);
    int    got;
    int    cyc;
    rExp_t e;
    pushRead(id, addr, len, burst);
    arHandshake(id, addr, len, burst);
    got = 0;
    cyc = 0;
    while (got <= int'(len) && cyc < 100) begin
      rready = stall ? !(cyc == 1 || cyc == 2) : 1'b1;
      if (rvalid && rq.size() > 0) begin
        if (rready) begin
          e = rq.pop_front();
          checkOutput("rdata", rdata, e.data);
          checkOutput("rresp", {30'b0, rresp}, {30'b0, e.resp});
          checkOutput("rlast", {31'b0, rlast}, {31'b0, e.last});
          checkOutput("rid", {28'b0, rid}, {28'b0, e.id});
          got++;
        end else begin
          checkOutput("rdata_stalled", rdata, rq[0].data);
          checkOutput("rlast_stalled", {31'b0, rlast}, {31'b0, rq[0].last});
        end
      end
      @(negedge aclk);
      cyc++;
    end
    rready = 1'b0;
    checkOutput("read_beats", got, int'(len) + 1);
    checkOutput("rvalid_done", {31'b0, rvalid}, 32'd0);
    checkOutput("arready_return", {31'b0, arready}, 32'd1);
  endtask

  // Main sequence: reset checks, functional bursts, error cases, stall and
  // mid-burst reset
  initial begin
    rExp_t e;
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    repeat (3) @(negedge aclk);
    checkOutput("rst_awready", {31'b0, awready}, 32'd0);
    checkOutput("rst_wready",  {31'b0, wready},  32'd0);
    checkOutput("rst_bvalid",  {31'b0, bvalid},  32'd0);
    checkOutput("rst_bresp",   {30'b0, bresp},   32'd0);
    checkOutput("rst_bid",     {28'b0, bid},     32'd0);
    checkOutput("rst_arready", {31'b0, arready}, 32'd0);
    checkOutput("rst_rvalid",  {31'b0, rvalid},  32'd0);
    checkOutput("rst_rlast",   {31'b0, rlast},   32'd0);
    checkOutput("rst_rdata",   rdata,            32'd0);
    checkOutput("rst_rresp",   {30'b0, rresp},   32'd0);
    checkOutput("rst_rid",     {28'b0, rid},     32'd0);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("post_rst_awready", {31'b0, awready}, 32'd1);
    checkOutput("post_rst_arready", {31'b0, arready}, 32'd1);

    $display("[TB] single beat");
    wBuf[0] = 32'hDEADBEEF;
    applyStimulus(4'h1, 32'h10, 8'd0, 2'd1, 4'hF, 1'b0, 0);
    readBurst(4'h2, 32'h10, 8'd0, 2'd1, 1'b0);

    $display("[TB] INCR 4 beats");
    for (int i = 0; i < 4; i++) wBuf[i] = i + 1;
    applyStimulus(4'h3, 32'h20, 8'd3, 2'd1, 4'hF, 1'b0, 2);
    readBurst(4'h4, 32'h20, 8'd3, 2'd1, 1'b0);

    $display("[TB] WRAP 4 beats");
    wBuf[0] = 32'hA1A1A1A1; wBuf[1] = 32'hB2B2B2B2; wBuf[2] = 32'hC3C3C3C3; wBuf[3] = 32'hD4D4D4D4;
    applyStimulus(4'h5, 32'h38, 8'd3, 2'd2, 4'hF, 1'b0, 0);
    readBurst(4'h6, 32'h30, 8'd3, 2'd1, 1'b0);
    readBurst(4'h7, 32'h38, 8'd3, 2'd2, 1'b0);

    $display("[TB] strobe merge");
    wBuf[0] = 32'hFFFFFFFF;
    applyStimulus(4'h8, 32'h40, 8'd0, 2'd1, 4'hF, 1'b0, 0);
    wBuf[0] = 32'h12345678;
    applyStimulus(4'h8, 32'h40, 8'd0, 2'd1, 4'h5, 1'b0, 0);
    readBurst(4'h9, 32'h40, 8'd0, 2'd1, 1'b0);

    $display("[TB] FIXED burst");
    wBuf[0] = 32'h00000005; wBuf[1] = 32'h00000006;
    applyStimulus(4'hA, 32'h70, 8'd1, 2'd0, 4'hF, 1'b0, 0);
    readBurst(4'hB, 32'h70, 8'd1, 2'd0, 1'b0);

    $display("[TB] error responses");
    wBuf[0] = 32'h11111111;
    applyStimulus(4'h1, 32'h0, 8'd0, 2'd1, 4'hF, 1'b0, 0);
    wBuf[0] = 32'h22222222;
    applyStimulus(4'h2, 32'h400, 8'd0, 2'd1, 4'hF, 1'b0, 0);
    readBurst(4'h3, 32'h0, 8'd0, 2'd1, 1'b0);
    wBuf[0] = 32'h33333333;
    applyStimulus(4'h4, 32'h40, 8'd0, 2'd3, 4'hF, 1'b0, 0);
    readBurst(4'h5, 32'h40, 8'd0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) wBuf[i] = 32'h44440000 + i;
    applyStimulus(4'h6, 32'h60, 8'd2, 2'd2, 4'hF, 1'b0, 0);
    readBurst(4'h7, 32'h400, 8'd0, 2'd1, 1'b0);
    readBurst(4'h8, 32'h20, 8'd1, 2'd3, 1'b0);
    wBuf[0] = 32'h55555555; wBuf[1] = 32'h66666666;
    applyStimulus(4'h9, 32'h80, 8'd1, 2'd1, 4'hF, 1'b1, 0);

    $display("[TB] stalled read");
    readBurst(4'hC, 32'h20, 8'd3, 2'd1, 1'b1);

    $display("[TB] reset mid-burst");
    pushRead(4'hD, 32'h20, 8'd3, 2'd1);
    arHandshake(4'hD, 32'h20, 8'd3, 2'd1);
    rready = 1'b1;
    e = rq.pop_front();
    checkOutput("mid_rdata0", rdata, e.data);
    @(negedge aclk);
    rready = 1'b0;
    #2 areset = 1'b1;
    #1;
    checkOutput("async_rvalid",  {31'b0, rvalid},  32'd0);
    checkOutput("async_rlast",   {31'b0, rlast},   32'd0);
    checkOutput("async_rdata",   rdata,            32'd0);
    checkOutput("async_arready", {31'b0, arready}, 32'd0);
    rq.delete();
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checkOutput("arready_before_edge", {31'b0, arready}, 32'd0);
    @(negedge aclk);
    checkOutput("arready_after_edge", {31'b0, arready}, 32'd1);
    checkOutput("awready_after_edge", {31'b0, awready}, 32'd1);
    readBurst(4'hE, 32'h20, 8'd0, 2'd1, 1'b0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
